// File: rtl/sync_fifo_prog_if.sv
// sync_fifo_prog_if: handshake, status and threshold signals of sync_fifo_prog.
//   master : producer/consumer side (drives w_en, w_data, r_en, thresholds, clr_flags)
//   slave  : FIFO side (drives r_data, occupancy count and all status flags)
// count, af_thresh and ae_thresh are aw+1 bits so they can represent 0..depth.
interface sync_fifo_prog_if #(
   parameter int width = 8,
   parameter int depth = 16
);
   localparam int aw = $clog2(depth);

   logic             w_en;
   logic [width-1:0] w_data;
   logic             r_en;
   logic [width-1:0] r_data;
   logic             full;
   logic             empty;
   logic             almost_full;
   logic             almost_empty;
   logic [aw:0]      count;
   logic [aw:0]      af_thresh;
   logic [aw:0]      ae_thresh;
   logic             overflow;
   logic             underflow;
   logic             clr_flags;

   modport master (
      output w_en, w_data, r_en, af_thresh, ae_thresh, clr_flags,
      input  r_data, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );

   modport slave (
      input  w_en, w_data, r_en, af_thresh, ae_thresh, clr_flags,
      output r_data, full, empty, almost_full, almost_empty, count,
             overflow, underflow
   );
endinterface

// File: rtl/sync_fifo_prog.sv
// sync_fifo_prog: single-clock FIFO with programmable almost-full/almost-empty
// thresholds, occupancy count, sticky overflow/underflow flags and an optional
// first-word-fall-through read mode.
//   clk    : clock, all logic on the rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : sync_fifo_prog_if.slave (write/read handshake, data, status, thresholds)
// Parameters: width (data bits), depth (entries, power of two >= 2),
//             fwft (0 = registered read with 1-cycle latency, 1 = fall-through).
module sync_fifo_prog #(
   parameter int width = 8,
   parameter int depth = 16,
   parameter int fwft  = 0
) (
   input logic             clk,
   input logic             rst_n,
   sync_fifo_prog_if.slave bus
);
   localparam int aw = $clog2(depth);
   localparam logic [aw:0] c_full_cnt = (aw+1)'(depth);

   logic [width-1:0] r_mem [depth];
   logic [aw-1:0]    r_wr_ptr;
   logic [aw-1:0]    r_rd_ptr;
   logic [aw:0]      r_count;
   logic             r_full;
   logic             r_empty;
   logic             r_af;
   logic             r_ae;
   logic             r_ovf;
   logic             r_unf;
   logic             r_arm;

   logic [aw:0]      w_count_nxt;
   logic             w_wr_acc;
   logic             w_rd_acc;
   logic             w_ovf_set;
   logic             w_unf_set;

   // r_arm stays low for the first edge after reset release so that a request
   // already present when rst_n rises is not captured.
   always_comb begin
      w_wr_acc    = r_arm & bus.w_en & ~r_full;
      w_rd_acc    = r_arm & bus.r_en & ~r_empty;
      w_ovf_set   = r_arm & bus.w_en & r_full;
      w_unf_set   = r_arm & bus.r_en & r_empty;
      w_count_nxt = r_count;
      case ({w_wr_acc, w_rd_acc})
         2'b10:   w_count_nxt = r_count + 1'b1;
         2'b01:   w_count_nxt = r_count - 1'b1;
         default: w_count_nxt = r_count;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_arm    <= 1'b0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
         r_af     <= 1'b0;
         r_ae     <= 1'b1;
         r_ovf    <= 1'b0;
         r_unf    <= 1'b0;
      end else begin
         r_arm <= 1'b1;
         if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
         r_count <= w_count_nxt;
         // All flags come from the next count so they always agree with count.
         r_full  <= (w_count_nxt == c_full_cnt);
         r_empty <= (w_count_nxt == '0);
         r_af    <= (bus.af_thresh != '0) && (w_count_nxt >= bus.af_thresh);
         r_ae    <= (w_count_nxt <= bus.ae_thresh);
         // Set has priority over clear.
         if (w_ovf_set)          r_ovf <= 1'b1;
         else if (bus.clr_flags) r_ovf <= 1'b0;
         if (w_unf_set)          r_unf <= 1'b1;
         else if (bus.clr_flags) r_unf <= 1'b0;
      end
   end

   // Storage is deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_acc) r_mem[r_wr_ptr] <= bus.w_data;
   end

   generate
      if (fwft != 0) begin : g_fwft
         assign bus.r_data = r_mem[r_rd_ptr];
      end else begin : g_std
         logic [width-1:0] r_rdata;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)        r_rdata <= '0;
            else if (w_rd_acc) r_rdata <= r_mem[r_rd_ptr];
         end
         assign bus.r_data = r_rdata;
      end
   endgenerate

   assign bus.count        = r_count;
   assign bus.full         = r_full;
   assign bus.empty        = r_empty;
   assign bus.almost_full  = r_af;
   assign bus.almost_empty = r_ae;
   assign bus.overflow     = r_ovf;
   assign bus.underflow    = r_unf;
endmodule

// File: tb/tb_sync_fifo_prog.sv
// tb_sync_fifo_prog: drives a standard-mode and an FWFT-mode sync_fifo_prog with
// identical stimulus and compares both against a queue-based reference model,
// a directed vector table, and the hand-written corner-case sequences.
module tb_sync_fifo_prog;
   localparam int W = 8;
   localparam int D = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sync_fifo_prog_if #(.width(W), .depth(D)) if_std ();
   sync_fifo_prog_if #(.width(W), .depth(D)) if_fw ();

   sync_fifo_prog #(.width(W), .depth(D), .fwft(0)) u_std (
      .clk(clk), .rst_n(rst_n), .bus(if_std.slave));
   sync_fifo_prog #(.width(W), .depth(D), .fwft(1)) u_fw (
      .clk(clk), .rst_n(rst_n), .bus(if_fw.slave));

   logic         t_we, t_re, t_clr;
   logic [W-1:0] t_wd;
   logic [4:0]   t_af, t_ae;

   assign if_std.w_en      = t_we;
   assign if_std.w_data    = t_wd;
   assign if_std.r_en      = t_re;
   assign if_std.clr_flags = t_clr;
   assign if_std.af_thresh = t_af;
   assign if_std.ae_thresh = t_ae;
   assign if_fw.w_en       = t_we;
   assign if_fw.w_data     = t_wd;
   assign if_fw.r_en       = t_re;
   assign if_fw.clr_flags  = t_clr;
   assign if_fw.af_thresh  = t_af;
   assign if_fw.ae_thresh  = t_ae;

   int n_chk = 0;
   int n_pass = 0;
   string phase = "init";

   // Reference model
   logic [W-1:0] q[$];
   logic         m_ovf, m_unf, m_af, m_ae, m_guard;
   logic [W-1:0] m_rd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s.%s: got %0h, want %0h", phase, name, act, exp);
   endtask

   task automatic model_reset();
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_af = 1'b0; m_ae = 1'b1;
      m_rd = '0; m_guard = 1'b1;
   endtask

   task automatic model_edge();
      int  n = q.size();
      logic wv = !m_guard && t_we;
      logic rv = !m_guard && t_re;
      if (rv && n != 0) m_rd = q.pop_front();
      if (wv && n != D) q.push_back(t_wd);
      if (wv && n == D)  m_ovf = 1'b1;
      else if (t_clr)    m_ovf = 1'b0;
      if (rv && n == 0)  m_unf = 1'b1;
      else if (t_clr)    m_unf = 1'b0;
      m_af = (t_af != 0) && (q.size() >= int'(t_af));
      m_ae = (q.size() <= int'(t_ae));
      m_guard = 1'b0;
   endtask

   task automatic check_all();
      check("count",    if_std.count, q.size());
      check("full",     if_std.full, q.size() == D);
      check("empty",    if_std.empty, q.size() == 0);
      check("afull",    if_std.almost_full, m_af);
      check("aempty",   if_std.almost_empty, m_ae);
      check("ovf",      if_std.overflow, m_ovf);
      check("unf",      if_std.underflow, m_unf);
      check("rdata",    if_std.r_data, m_rd);
      check("fw_count", if_fw.count, q.size());
      check("fw_empty", if_fw.empty, q.size() == 0);
      check("fw_ovf",   if_fw.overflow, m_ovf);
      if (q.size() != 0) check("fw_rdata", if_fw.r_data, q[0]);
   endtask

   task automatic cyc(input logic we, input logic [W-1:0] wd, input logic re, input logic clr);
      t_we = we; t_wd = wd; t_re = re; t_clr = clr;
      @(posedge clk);
      model_edge();
      #1;
      check_all();
   endtask

   task automatic async_reset();
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      t_we = 1'b0; t_re = 1'b0; t_clr = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   typedef struct {
      logic we; logic [W-1:0] wd; logic re; logic clr;
      int   cnt; logic emp, ful, af, ae, ovf, unf;
      logic [W-1:0] rd; logic [W-1:0] fw;
   } vec_t;

   vec_t tbl[10];

   initial begin
      // af=3, ae=1, starting from an empty FIFO with r_data=0
      tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h11};
      tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h11};
      tbl[2] = '{1'b1, 8'h33, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22};
      tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 8'h22};
      tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h22, 8'h33};
      tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h33, 8'h44};
      tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h00};
      tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00};
      tbl[8] = '{1'b1, 8'h55, 1'b1, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h55};
      tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h44, 8'h55};

      t_we = 1'b0; t_re = 1'b0; t_clr = 1'b0; t_wd = '0; t_af = 5'd3; t_ae = 5'd1;
      model_reset();
      #12;
      phase = "reset";
      check_all();
      check("rst_aempty", if_std.almost_empty, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Requests on the first edge after release must be ignored
      phase = "guard";
      cyc(1'b1, 8'hEE, 1'b1, 1'b0);
      check("guard_cnt", if_std.count, 0);
      check("guard_unf", if_std.underflow, 1'b0);

      phase = "table";
      for (int i = 0; i < 10; i++) begin
         t_we = tbl[i].we; t_wd = tbl[i].wd; t_re = tbl[i].re; t_clr = tbl[i].clr;
         @(posedge clk);
         model_edge();
         #1;
         check($sformatf("v%0d_cnt", i),   if_std.count, tbl[i].cnt);
         check($sformatf("v%0d_emp", i),   if_std.empty, tbl[i].emp);
         check($sformatf("v%0d_ful", i),   if_std.full, tbl[i].ful);
         check($sformatf("v%0d_af", i),    if_std.almost_full, tbl[i].af);
         check($sformatf("v%0d_ae", i),    if_std.almost_empty, tbl[i].ae);
         check($sformatf("v%0d_ovf", i),   if_std.overflow, tbl[i].ovf);
         check($sformatf("v%0d_unf", i),   if_std.underflow, tbl[i].unf);
         check($sformatf("v%0d_rd", i),    if_std.r_data, tbl[i].rd);
         if (!tbl[i].emp) check($sformatf("v%0d_fw", i), if_fw.r_data, tbl[i].fw);
      end
      cyc(1'b0, 8'h00, 1'b1, 1'b0);

      phase = "fill";
      t_af = 5'd14; t_ae = 5'd2;
      for (int i = 0; i < 16; i++) begin
         cyc(1'b1, 8'(i), 1'b0, 1'b0);
         if (i == 12) check("af_before", if_std.almost_full, 1'b0);
         if (i == 13) check("af_rise", if_std.almost_full, 1'b1);
         if (i == 14) check("not_full", if_std.full, 1'b0);
      end
      check("full16", if_std.full, 1'b1);
      check("cnt16", if_std.count, 16);
      cyc(1'b1, 8'hAA, 1'b0, 1'b0);
      check("ovf_set", if_std.overflow, 1'b1);
      check("cnt_hold", if_std.count, 16);

      phase = "prio";
      cyc(1'b1, 8'hBB, 1'b0, 1'b1);
      check("ovf_setwins", if_std.overflow, 1'b1);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);
      check("ovf_clr", if_std.overflow, 1'b0);

      phase = "drain";
      for (int i = 0; i < 16; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         check($sformatf("rd%0d", i), if_std.r_data, i);
         if (i == 0) check("full_drop", if_std.full, 1'b0);
      end
      check("empty16", if_std.empty, 1'b1);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("unf_set", if_std.underflow, 1'b1);
      check("rd_hold", if_std.r_data, 8'h0F);
      cyc(1'b0, 8'h00, 1'b0, 1'b1);

      phase = "fwft";
      cyc(1'b1, 8'h5A, 1'b0, 1'b0);
      check("fw_show", if_fw.r_data, 8'h5A);
      check("fw_nempty", if_fw.empty, 1'b0);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
      check("fw_pop", if_fw.empty, 1'b1);

      phase = "wrap";
      for (int i = 0; i < 8; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) begin
         cyc(1'b1, 8'(8 + i), 1'b1, 1'b0);
         check("wrap_cnt", if_std.count, 8);
         check("wrap_rd", if_std.r_data, 8'(i));
      end
      check("wrap_ovf", if_std.overflow, 1'b0);
      check("wrap_unf", if_std.underflow, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

      phase = "midrst";
      for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
      check("pre_cnt", if_std.count, 9);
      async_reset();
      check("rst_cnt", if_std.count, 0);
      check("rst_empty", if_std.empty, 1'b1);
      check("rst_rd", if_std.r_data, 8'h00);
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 8'h00, 1'b1, 1'b0);
         check($sformatf("post_rd%0d", i), if_std.r_data, i);
      end

      phase = "random";
      begin
         int wprob = 50;
         int rprob = 50;
         for (int i = 0; i < 1500; i++) begin
            if (i % 100 == 0) begin
               wprob = $urandom_range(15, 85);
               rprob = $urandom_range(15, 85);
               t_af  = 5'($urandom_range(0, 16));
               t_ae  = 5'($urandom_range(0, 16));
            end
            cyc($urandom_range(0, 99) < wprob, 8'($urandom),
                $urandom_range(0, 99) < rprob, $urandom_range(0, 19) == 0);
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
